// File: rtl/fetch_hazard_unit.sv
// Fetch-stage PC register plus F/D and D/E enable/flush generation for
// redirects, load-use hazards and external fetch stalls. Optional perf
// counters are built when FETCH_PERF_COUNTERS_EN is defined.
module fetch_hazard_unit #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR   = '0,
  parameter logic [1:0]            LOAD_RESULTSRC = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallF_i,
  input  logic [1:0]            PCSrcE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  input  logic [DATA_WIDTH-1:0] ALUResultE_i,
  input  logic [4:0]            Rs1D_i,
  input  logic [4:0]            Rs2D_i,
  input  logic [4:0]            RdE_i,
  input  logic [1:0]            ResultSrcE_i,
  output logic [DATA_WIDTH-1:0] PCF_o,
  output logic [DATA_WIDTH-1:0] PCPlus4F_o,
  output logic                  Fen_o,
  output logic                  Frst_o,
  output logic                  Den_o,
  output logic                  Drst_o
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]           CycleCnt_o,
  output logic [31:0]           StallCnt_o,
  output logic [31:0]           FlushCnt_o
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, LDSTALL, HOLD} state_e;

  // What the pipeline does this cycle, resolved once from state and inputs.
  typedef enum logic [2:0] {
    ACT_BOOT, ACT_STALL, ACT_REDIR, ACT_PEND, ACT_LOADUSE, ACT_SEQ
  } action_e;

  state_e                  state_q, state_d;
  action_e                 action;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   pend_target_q, pend_target_d;
  logic                    pend_valid_q, pend_valid_d;

  logic                    redirect;
  logic                    load_use;
  logic [DATA_WIDTH-1:0]   redir_target;
  logic [DATA_WIDTH-1:0]   pc_plus4;

  assign redirect     = (PCSrcE_i == 2'b01) || (PCSrcE_i == 2'b10);
  assign redir_target = (PCSrcE_i == 2'b10) ? {ALUResultE_i[DATA_WIDTH-1:1], 1'b0}
                                            : PCTargetE_i;
  assign load_use     = (ResultSrcE_i == LOAD_RESULTSRC) && (RdE_i != 5'd0) &&
                        ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  assign pc_plus4     = pc_q + DATA_WIDTH'(4);

  assign PCF_o      = pc_q;
  assign PCPlus4F_o = pc_plus4;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Next-state process: priority resolution, then register updates.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    action        = ACT_SEQ;
    state_d       = RUN;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    unique case (state_q)
      BOOT:    action = ACT_BOOT;
      RUN: begin
        if (StallF_i)      action = ACT_STALL;
        else if (redirect) action = ACT_REDIR;
        else if (load_use) action = ACT_LOADUSE;
        else               action = ACT_SEQ;
      end
      // The load that caused the bubble is still in Execute; do not re-stall.
      LDSTALL: begin
        if (StallF_i)      action = ACT_STALL;
        else if (redirect) action = ACT_REDIR;
        else               action = ACT_SEQ;
      end
      HOLD: begin
        if (StallF_i)          action = ACT_STALL;
        else if (redirect)     action = ACT_REDIR;
        else if (pend_valid_q) action = ACT_PEND;
        else if (load_use)     action = ACT_LOADUSE;
        else                   action = ACT_SEQ;
      end
      default: action = ACT_BOOT;
    endcase

    unique case (action)
      ACT_BOOT:    state_d = RUN;
      ACT_STALL: begin
        state_d = HOLD;
        if (redirect) begin
          pend_valid_d  = 1'b1;
          pend_target_d = redir_target;
        end
      end
      ACT_REDIR: begin
        pc_d         = redir_target;
        pend_valid_d = 1'b0;
      end
      ACT_PEND: begin
        pc_d         = pend_target_q;
        pend_valid_d = 1'b0;
      end
      ACT_LOADUSE: state_d = LDSTALL;
      ACT_SEQ:     pc_d    = pc_plus4;
      default:     state_d = RUN;
    endcase
  end

  // Output process; reset forces the flush/disable pattern combinationally.
  always_comb begin
    Fen_o  = 1'b1;
    Den_o  = 1'b1;
    Frst_o = 1'b0;
    Drst_o = 1'b0;
    if (!rst_n) begin
      Fen_o  = 1'b0;
      Den_o  = 1'b0;
      Frst_o = 1'b1;
      Drst_o = 1'b1;
    end else begin
      unique case (action)
        ACT_BOOT, ACT_REDIR, ACT_PEND: begin
          Frst_o = 1'b1;
          Drst_o = 1'b1;
        end
        ACT_STALL: begin
          Fen_o = 1'b0;
          Den_o = 1'b0;
        end
        ACT_LOADUSE: begin
          Fen_o  = 1'b0;
          Drst_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    stall_cnt_d = stall_cnt_q + {31'd0, ~Fen_o};
    flush_cnt_d = flush_cnt_q + {31'd0, Frst_o && (state_q != BOOT)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign CycleCnt_o = cycle_cnt_q;
  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_hazard_unit.sv
// Self-checking bench for fetch_hazard_unit: directed scenarios followed by
// random traffic, compared cycle by cycle against a rule-level model.
module tb_fetch_hazard_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF_i;
  logic [1:0]  PCSrcE_i;
  logic [31:0] PCTargetE_i;
  logic [31:0] ALUResultE_i;
  logic [4:0]  Rs1D_i, Rs2D_i, RdE_i;
  logic [1:0]  ResultSrcE_i;
  logic [31:0] PCF_o, PCPlus4F_o;
  logic        Fen_o, Frst_o, Den_o, Drst_o;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] CycleCnt_o, StallCnt_o, FlushCnt_o;
`endif

  always #5 clk = ~clk;

  fetch_hazard_unit #(
    .DATA_WIDTH(32), .RESET_VECTOR(RV), .LOAD_RESULTSRC(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n), .StallF_i(StallF_i), .PCSrcE_i(PCSrcE_i),
    .PCTargetE_i(PCTargetE_i), .ALUResultE_i(ALUResultE_i),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .RdE_i(RdE_i), .ResultSrcE_i(ResultSrcE_i),
    .PCF_o(PCF_o), .PCPlus4F_o(PCPlus4F_o), .Fen_o(Fen_o), .Frst_o(Frst_o),
    .Den_o(Den_o), .Drst_o(Drst_o)
`ifdef FETCH_PERF_COUNTERS_EN
    , .CycleCnt_o(CycleCnt_o), .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the fetch PC, whether this is the first cycle after reset,
  // whether the previous cycle was a load-use bubble, and the held redirect.
  logic [31:0] m_pc, m_pend_t, n_pc, n_pend_t;
  bit          m_boot, m_after_load, m_pend_v, n_after_load, n_pend_v;
  bit          e_fen, e_den, e_frst, e_drst;
  int unsigned m_cyc, m_stl, m_fl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_boot = 1; m_after_load = 0; m_pend_v = 0; m_pend_t = '0;
    m_cyc = 0; m_stl = 0; m_fl = 0;
  endtask

  task automatic model_eval();
    bit          redir;
    bit          lu;
    logic [31:0] tgt;
    redir = (PCSrcE_i == 2'd1) || (PCSrcE_i == 2'd2);
    tgt   = (PCSrcE_i == 2'd2) ? (ALUResultE_i & 32'hFFFF_FFFE) : PCTargetE_i;
    lu    = (ResultSrcE_i == 2'b01) && (RdE_i != 0) && (RdE_i == Rs1D_i || RdE_i == Rs2D_i);
    n_pc = m_pc; n_after_load = 0; n_pend_v = m_pend_v; n_pend_t = m_pend_t;
    if (m_boot) begin
      {e_fen, e_den, e_frst, e_drst} = 4'b1111;
    end else if (StallF_i) begin
      {e_fen, e_den, e_frst, e_drst} = 4'b0000;
      if (redir) begin n_pend_v = 1; n_pend_t = tgt; end
    end else if (redir || m_pend_v) begin
      {e_fen, e_den, e_frst, e_drst} = 4'b1111;
      n_pc = redir ? tgt : m_pend_t;
      n_pend_v = 0;
    end else if (lu && !m_after_load) begin
      {e_fen, e_den, e_frst, e_drst} = 4'b0101;
      n_after_load = 1;
    end else begin
      {e_fen, e_den, e_frst, e_drst} = 4'b1100;
      n_pc = m_pc + 32'd4;
    end
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle();
    #1;
    model_eval();
    check("pcf", PCF_o, m_pc);
    check("pcplus4", PCPlus4F_o, m_pc + 32'd4);
    check("fen", {31'd0, Fen_o}, {31'd0, e_fen});
    check("den", {31'd0, Den_o}, {31'd0, e_den});
    check("frst", {31'd0, Frst_o}, {31'd0, e_frst});
    check("drst", {31'd0, Drst_o}, {31'd0, e_drst});
`ifdef FETCH_PERF_COUNTERS_EN
    check("cyc_cnt", CycleCnt_o, m_cyc);
    check("stall_cnt", StallCnt_o, m_stl);
    check("flush_cnt", FlushCnt_o, m_fl);
`endif
    @(posedge clk);
    #1;
    m_cyc++;
    if (!e_fen) m_stl++;
    if (e_frst && !m_boot) m_fl++;
    m_pc = n_pc; m_boot = 0; m_after_load = n_after_load;
    m_pend_v = n_pend_v; m_pend_t = n_pend_t;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pcf"}, PCF_o, RV);
    check({tag, "_en"}, {30'd0, Fen_o, Den_o}, 32'd0);
    check({tag, "_flush"}, {30'd0, Frst_o, Drst_o}, 32'd3);
  endtask

  task automatic idle_inputs();
    StallF_i = 0; PCSrcE_i = 0; PCTargetE_i = '0; ALUResultE_i = '0;
    Rs1D_i = 0; Rs2D_i = 0; RdE_i = 0; ResultSrcE_i = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    #1;
    check_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();

    // Boot cycle, then sequential fetch 0,4,8,C,10.
    #1 check("boot_flush", {30'd0, Frst_o, Drst_o}, 32'd3);
    cycle();
    check("boot_pc", PCF_o, 32'h0);
    repeat (4) cycle();
    check("seq_pc", PCF_o, 32'h10);

    // Branch taken.
    PCSrcE_i = 2'b01; PCTargetE_i = 32'h40;
    #1 check("br_flush", {30'd0, Frst_o, Drst_o}, 32'd3);
    cycle();
    check("br_pc", PCF_o, 32'h40);

    // JALR clears bit 0.
    PCSrcE_i = 2'b10; ALUResultE_i = 32'h81;
    cycle();
    check("jalr_pc", PCF_o, 32'h80);

    // Move to 0x20 then a load-use hazard on Rs2.
    PCSrcE_i = 2'b01; PCTargetE_i = 32'h20;
    cycle();
    PCSrcE_i = 2'b00;
    ResultSrcE_i = 2'b01; RdE_i = 5'd5; Rs2D_i = 5'd5; Rs1D_i = 5'd1;
    #1 check("lu_fen", {31'd0, Fen_o}, 32'd0);
    cycle();
    check("lu_hold", PCF_o, 32'h20);
    cycle();
    check("lu_once", PCF_o, 32'h24);
    RdE_i = 5'd0; Rs2D_i = 5'd0; Rs1D_i = 5'd0;
    #1 check("x0_nostall", {31'd0, Fen_o}, 32'd1);
    cycle();
    check("x0_pc", PCF_o, 32'h28);
    ResultSrcE_i = 2'b00;

    // External stall with a redirect pulse in its 2nd cycle.
    StallF_i = 1;
    cycle();
    PCSrcE_i = 2'b01; PCTargetE_i = 32'h100;
    cycle();
    PCSrcE_i = 2'b00; PCTargetE_i = 32'h0;
    cycle();
    check("hold_pc", PCF_o, 32'h28);
    StallF_i = 0;
    #1 check("hold_exit_flush", {30'd0, Frst_o, Drst_o}, 32'd3);
    cycle();
    check("pend_pc", PCF_o, 32'h100);

    // PC wrap at the top of the address space.
    PCSrcE_i = 2'b01; PCTargetE_i = 32'hFFFF_FFFC;
    cycle();
    PCSrcE_i = 2'b00;
    #1 check("wrap_plus4", PCPlus4F_o, 32'h0);
    cycle();
    check("wrap_pc", PCF_o, 32'h0);

    // Reset while holding a pending redirect.
    StallF_i = 1; PCSrcE_i = 2'b01; PCTargetE_i = 32'h200;
    cycle();
    PCSrcE_i = 2'b00;
    cycle();
    rst_n = 0;
    #1 check_reset("mid_reset");
    @(posedge clk);
    #1 rst_n = 1;
    idle_inputs();
    model_reset();
    repeat (4) cycle();
    check("no_stale_pend", PCF_o, 32'hC);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 0;
        #1 check_reset("rand_reset");
        @(posedge clk);
        #1 rst_n = 1;
        model_reset();
      end
      StallF_i     = ($urandom_range(0, 3) == 0);
      PCSrcE_i     = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      PCTargetE_i  = $urandom & 32'hFFFF_FFFC;
      ALUResultE_i = $urandom;
      Rs1D_i       = 5'($urandom_range(0, 3));
      Rs2D_i       = 5'($urandom_range(0, 3));
      RdE_i        = 5'($urandom_range(0, 3));
      ResultSrcE_i = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_hazard_unit.md
Name: fetch_hazard_unit

Overview:
- Upstream neighbour of the control pipeline. Owns the fetch-stage PC register and produces PCF/PCPlus4F.
- Generates the pipeline-register enables and flushes (Fen/Frst for F/D, Den/Drst for D/E) that the control/decode pipeline consumes.
- Resolves three things with fixed priority: branch/jump redirects from Execute, load-use hazards, and external fetch stalls.
- Holds any redirect that arrives during an external stall until it can be applied.

Parameters:
- DATA_WIDTH, 32, PC and data width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- LOAD_RESULTSRC, 2'b01, ResultSrcE encoding that marks a load.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- StallF_i  in  1  external fetch stall (instruction memory not ready).
- PCSrcE_i  in  2  redirect request: 00 sequential, 01 branch taken, 10 jump (JALR), 11 reserved.
- PCTargetE_i  in  DATA_WIDTH  branch/JAL target computed in Execute.
- ALUResultE_i  in  DATA_WIDTH  JALR target computed in Execute.
- Rs1D_i  in  5  decode-stage source register 1.
- Rs2D_i  in  5  decode-stage source register 2.
- RdE_i  in  5  execute-stage destination register.
- ResultSrcE_i  in  2  execute-stage result source.
- PCF_o  out  DATA_WIDTH  current fetch PC (registered).
- PCPlus4F_o  out  DATA_WIDTH  PCF_o+4.
- Fen_o  out  1  F/D register enable.
- Frst_o  out  1  F/D register flush.
- Den_o  out  1  D/E register enable.
- Drst_o  out  1  D/E register flush.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - PCF_o=RESET_VECTOR; state=BOOT; pend_valid=0.
  - Fen_o=0, Den_o=0, Frst_o=1, Drst_o=1.
- PCPlus4F_o = PCF_o+4, combinational, wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC -> 0).
- Redirect target:
  - 01 -> PCTargetE_i.
  - 10 -> {ALUResultE_i[DW-1:1],1'b0}.
  - 11 -> treated as 00.
- States: BOOT, RUN, LDSTALL, HOLD.
- BOOT (exactly 1 cycle after reset release):
  - PC held; Frst_o=1, Drst_o=1, Fen_o=1, Den_o=1.
  - Next state RUN.
- RUN, evaluated in priority order (first match wins):
  1. StallF_i=1: PC held; Fen_o=0, Den_o=0, no flush. If a redirect is present, latch its target into pend_target and set pend_valid=1. Next state HOLD.
  2. Redirect (PCSrcE_i in {01,10}): PCF_o<=target on the next edge; Frst_o=1, Drst_o=1, Fen_o=1, Den_o=1. A redirect overrides a load-use hazard in the same cycle. Next state RUN.
  3. Load-use (ResultSrcE_i==LOAD_RESULTSRC && RdE_i!=0 && (RdE_i==Rs1D_i || RdE_i==Rs2D_i)): PC held; Fen_o=0, Drst_o=1 (bubble), Den_o=1. Next state LDSTALL.
  4. Otherwise: PCF_o<=PCPlus4F_o; Fen_o=1, Den_o=1, no flush.
- LDSTALL (1 cycle):
  - Behaves as RUN except load-use detection is suppressed, so the same load cannot stall twice.
  - Redirect and StallF_i keep their RUN priority.
  - Next state RUN, or HOLD if StallF_i=1.
- HOLD (while StallF_i=1):
  - PC held; Fen_o=0, Den_o=0.
  - A new redirect overwrites pend_target (the latest one wins).
- HOLD exit (StallF_i=0):
  - If pend_valid=1 or a redirect is present: PCF_o<=redirect target if present, else pend_target. Frst_o=1, Drst_o=1. Clear pend_valid.
  - Otherwise behave exactly as RUN for that cycle.
  - Next state RUN.
- Reset mid-operation: asynchronous return to BOOT; pend_valid is cleared and the pending redirect is discarded.
- Outputs are combinational from state and inputs, except PCF_o, which is registered.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- When defined: adds 32-bit outputs CycleCnt_o, StallCnt_o, FlushCnt_o.
  - All three reset to 0 and wrap on overflow.
  - CycleCnt_o increments every cycle out of reset.
  - StallCnt_o increments on every cycle where Fen_o=0.
  - FlushCnt_o increments on every cycle where Frst_o=1, excluding BOOT.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release with RESET_VECTOR=0 -> BOOT cycle: PCF_o=0, Frst_o=Drst_o=1. Then PCF_o=0,4,8,12 on successive cycles.
- PCF_o=32'h10, PCSrcE_i=01, PCTargetE_i=32'h40 -> same cycle Frst_o=Drst_o=1; next cycle PCF_o=32'h40.
- PCSrcE_i=10, ALUResultE_i=32'h81 -> next PCF_o=32'h80.
- ResultSrcE_i=01, RdE_i=5, Rs2D_i=5 at PCF_o=32'h20 -> one cycle Fen_o=0, Drst_o=1, PCF_o holds 32'h20. Next cycle advances to 32'h24. Repeating with RdE_i=0 -> no stall.
- StallF_i=1 for 3 cycles with a PCSrcE_i=01 pulse (target 32'h100) in the 2nd cycle -> PCF_o held throughout, Fen_o=Den_o=0. On the first cycle after StallF_i falls, Frst_o=Drst_o=1; next PCF_o=32'h100.
- rst_n asserted while in HOLD with a pending redirect -> PCF_o=RESET_VECTOR immediately; after release the pending target is never applied.
